// File: rtl/reorder_buffer.sv
// ============================================================================
//  Module      : reorder_buffer
//  Description : In-order retirement buffer for the Tomasulo core. Allocates
//                one entry per dispatched instruction, captures results from
//                the CDB, retires the head in program order onto the register
//                file write port, forwards operands to the reservation
//                stations, and flushes when a mispredicted branch retires.
//  Ports       : clk/rst/rdy          - clock, sync active-high reset, enable
//                alloc_*              - dispatch allocation request / tag
//                rob_full, rob_empty  - occupancy status
//                cdb_*                - common data bus result broadcast
//                q1_*/q2_*            - combinational operand lookups
//                rd_out_flag/rd_out/rd_val/commit_tag - registered retire port
//                flush_out/flush_pc   - registered flush pulse and restart PC
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reorder_buffer #(
  parameter int ROB_AW   = 4,
  parameter int ROB_SIZE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              alloc_valid,
  input  logic              alloc_has_rd,
  input  logic [4:0]        alloc_rd,
  output logic [ROB_AW-1:0] alloc_tag,
  output logic              rob_full,
  output logic              rob_empty,
  input  logic              cdb_valid,
  input  logic [ROB_AW-1:0] cdb_tag,
  input  logic [31:0]       cdb_val,
  input  logic              cdb_mispredict,
  input  logic [31:0]       cdb_target,
  input  logic [ROB_AW-1:0] q1_tag,
  input  logic [ROB_AW-1:0] q2_tag,
  output logic              q1_ready,
  output logic              q2_ready,
  output logic [31:0]       q1_val,
  output logic [31:0]       q2_val,
  output logic              rd_out_flag,
  output logic [4:0]        rd_out,
  output logic [31:0]       rd_val,
  output logic [ROB_AW-1:0] commit_tag,
  output logic              flush_out,
  output logic [31:0]       flush_pc
);

  localparam logic [ROB_AW:0] FULL_CNT = (ROB_AW+1)'(ROB_SIZE);

  // Entry storage
  logic [ROB_SIZE-1:0] busy_q,   busy_d;
  logic [ROB_SIZE-1:0] ready_q,  ready_d;
  logic [ROB_SIZE-1:0] has_rd_q, has_rd_d;
  logic [ROB_SIZE-1:0] mis_q,    mis_d;
  logic [4:0]          rd_q     [ROB_SIZE];
  logic [4:0]          rd_d     [ROB_SIZE];
  logic [31:0]         val_q    [ROB_SIZE];
  logic [31:0]         val_d    [ROB_SIZE];
  logic [31:0]         target_q [ROB_SIZE];
  logic [31:0]         target_d [ROB_SIZE];

  // Pointers and occupancy
  logic [ROB_AW-1:0] head_q,  head_d;
  logic [ROB_AW-1:0] tail_q,  tail_d;
  logic [ROB_AW:0]   count_q, count_d;

  // Registered outputs
  logic              rd_out_flag_q, rd_out_flag_d;
  logic [4:0]        rd_out_q,      rd_out_d;
  logic [31:0]       rd_val_q,      rd_val_d;
  logic [ROB_AW-1:0] commit_tag_q,  commit_tag_d;
  logic              flush_out_q,   flush_out_d;
  logic [31:0]       flush_pc_q,    flush_pc_d;

  logic do_alloc;
  logic do_retire;
  logic do_flush;

  assign rob_full  = (count_q == FULL_CNT);
  assign rob_empty = (count_q == '0);
  assign alloc_tag = tail_q;

  // Full check uses the registered count, so a same-cycle retire never
  // frees room for an allocation.
  assign do_alloc  = alloc_valid && !rob_full;
  assign do_retire = busy_q[head_q] && ready_q[head_q];
  assign do_flush  = do_retire && mis_q[head_q];

  // Operand lookup: a live CDB broadcast wins over the stored entry.
  always_comb begin
    q1_ready = busy_q[q1_tag] && ready_q[q1_tag];
    q1_val   = val_q[q1_tag];
    q2_ready = busy_q[q2_tag] && ready_q[q2_tag];
    q2_val   = val_q[q2_tag];
    if (cdb_valid && (cdb_tag == q1_tag)) begin
      q1_ready = 1'b1;
      q1_val   = cdb_val;
    end
    if (cdb_valid && (cdb_tag == q2_tag)) begin
      q2_ready = 1'b1;
      q2_val   = cdb_val;
    end
  end

  always_comb begin
    busy_d        = busy_q;
    ready_d       = ready_q;
    has_rd_d      = has_rd_q;
    mis_d         = mis_q;
    rd_d          = rd_q;
    val_d         = val_q;
    target_d      = target_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    rd_out_flag_d = 1'b0;
    rd_out_d      = rd_out_q;
    rd_val_d      = rd_val_q;
    commit_tag_d  = commit_tag_q;
    flush_out_d   = 1'b0;
    flush_pc_d    = flush_pc_q;

    if (rdy) begin
      if (do_alloc) begin
        busy_d[tail_q]   = 1'b1;
        ready_d[tail_q]  = 1'b0;
        mis_d[tail_q]    = 1'b0;
        has_rd_d[tail_q] = alloc_has_rd;
        rd_d[tail_q]     = alloc_rd;
        tail_d           = tail_q + 1'b1;
      end

      // Only entries already busy in registered state accept a result.
      if (cdb_valid && busy_q[cdb_tag]) begin
        ready_d[cdb_tag]  = 1'b1;
        val_d[cdb_tag]    = cdb_val;
        mis_d[cdb_tag]    = cdb_mispredict;
        target_d[cdb_tag] = cdb_target;
      end

      if (do_retire) begin
        rd_out_flag_d  = has_rd_q[head_q] && (rd_q[head_q] != 5'd0);
        rd_out_d       = rd_q[head_q];
        rd_val_d       = val_q[head_q];
        commit_tag_d   = head_q;
        busy_d[head_q] = 1'b0;
        head_d         = head_q + 1'b1;
      end

      if (do_alloc && !do_retire) begin
        count_d = count_q + 1'b1;
      end else if (do_retire && !do_alloc) begin
        count_d = count_q - 1'b1;
      end

      // Mispredicted branch at head: discard everything younger, including
      // any allocation or CDB capture from this cycle.
      if (do_flush) begin
        flush_out_d = 1'b1;
        flush_pc_d  = target_q[head_q];
        busy_d      = '0;
        head_d      = '0;
        tail_d      = '0;
        count_d     = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      ready_q       <= '0;
      has_rd_q      <= '0;
      mis_q         <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        rd_q[i]     <= '0;
        val_q[i]    <= '0;
        target_q[i] <= '0;
      end
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      rd_out_flag_q <= 1'b0;
      rd_out_q      <= '0;
      rd_val_q      <= '0;
      commit_tag_q  <= '0;
      flush_out_q   <= 1'b0;
      flush_pc_q    <= '0;
    end else begin
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      has_rd_q      <= has_rd_d;
      mis_q         <= mis_d;
      rd_q          <= rd_d;
      val_q         <= val_d;
      target_q      <= target_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      rd_out_flag_q <= rd_out_flag_d;
      rd_out_q      <= rd_out_d;
      rd_val_q      <= rd_val_d;
      commit_tag_q  <= commit_tag_d;
      flush_out_q   <= flush_out_d;
      flush_pc_q    <= flush_pc_d;
    end
  end

  assign rd_out_flag = rd_out_flag_q;
  assign rd_out      = rd_out_q;
  assign rd_val      = rd_val_q;
  assign commit_tag  = commit_tag_q;
  assign flush_out   = flush_out_q;
  assign flush_pc    = flush_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// ============================================================================
//  Module      : tb_reorder_buffer
//  Description : Directed-vector bench for reorder_buffer with hand-computed
//                expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        alloc_valid;
  logic        alloc_has_rd;
  logic [4:0]  alloc_rd;
  logic [3:0]  alloc_tag;
  logic        rob_full;
  logic        rob_empty;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic        cdb_mispredict;
  logic [31:0] cdb_target;
  logic [3:0]  q1_tag;
  logic [3:0]  q2_tag;
  logic        q1_ready;
  logic        q2_ready;
  logic [31:0] q1_val;
  logic [31:0] q2_val;
  logic        rd_out_flag;
  logic [4:0]  rd_out;
  logic [31:0] rd_val;
  logic [3:0]  commit_tag;
  logic        flush_out;
  logic [31:0] flush_pc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.ROB_AW(4), .ROB_SIZE(16)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_has_rd(alloc_has_rd), .alloc_rd(alloc_rd),
    .alloc_tag(alloc_tag), .rob_full(rob_full), .rob_empty(rob_empty),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_val(q1_val), .q2_val(q2_val),
    .rd_out_flag(rd_out_flag), .rd_out(rd_out), .rd_val(rd_val),
    .commit_tag(commit_tag), .flush_out(flush_out), .flush_pc(flush_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic has_rd, input logic [4:0] rd);
    alloc_valid  = 1'b1;
    alloc_has_rd = has_rd;
    alloc_rd     = rd;
    tick();
    alloc_valid  = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] val,
                     input logic mis, input logic [31:0] tgt);
    cdb_valid      = 1'b1;
    cdb_tag        = tag;
    cdb_val        = val;
    cdb_mispredict = mis;
    cdb_target     = tgt;
    tick();
    cdb_valid      = 1'b0;
    cdb_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    alloc_valid = 1'b0; alloc_has_rd = 1'b0; alloc_rd = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0; cdb_mispredict = 1'b0; cdb_target = '0;
    q1_tag = '0; q2_tag = '0;

    // 1. Reset and idle
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    check("rst_empty", 32'(rob_empty), 32'd1);
    check("rst_full", 32'(rob_full), 32'd0);
    check("rst_rd_flag", 32'(rd_out_flag), 32'd0);
    check("rst_flush", 32'(flush_out), 32'd0);

    // 2. Out-of-order completion, in-order retirement
    alloc(1'b1, 5'd5);
    alloc(1'b1, 5'd6);
    alloc(1'b1, 5'd0);
    check("t2_alloc_tag", 32'(alloc_tag), 32'd3);
    cdb(4'd1, 32'h22, 1'b0, 32'h0);
    check("t2_no_early_retire", 32'(rd_out_flag), 32'd0);
    cdb(4'd0, 32'h11, 1'b0, 32'h0);
    check("t2_head_not_yet", 32'(rd_out_flag), 32'd0);
    cdb(4'd2, 32'h33, 1'b0, 32'h0);
    check("t2_r0_flag", 32'(rd_out_flag), 32'd1);
    check("t2_r0_rd", 32'(rd_out), 32'd5);
    check("t2_r0_val", rd_val, 32'h11);
    check("t2_r0_tag", 32'(commit_tag), 32'd0);
    tick();
    check("t2_r1_flag", 32'(rd_out_flag), 32'd1);
    check("t2_r1_rd", 32'(rd_out), 32'd6);
    check("t2_r1_val", rd_val, 32'h22);
    tick();
    check("t2_r2_flag", 32'(rd_out_flag), 32'd0);
    check("t2_r2_tag", 32'(commit_tag), 32'd2);
    tick();
    check("t2_empty", 32'(rob_empty), 32'd1);
    check("t2_flag_pulse", 32'(rd_out_flag), 32'd0);

    // 3. Fill, overflow attempt, wrap
    do_reset();
    for (int i = 0; i < 16; i++) alloc(1'b1, 5'(i + 1));
    check("t3_full", 32'(rob_full), 32'd1);
    check("t3_full_tag", 32'(alloc_tag), 32'd0);
    alloc(1'b1, 5'd31);
    check("t3_ovf_tag", 32'(alloc_tag), 32'd0);
    check("t3_ovf_full", 32'(rob_full), 32'd1);
    cdb(4'd0, 32'h55, 1'b0, 32'h0);
    tick();
    check("t3_ret_flag", 32'(rd_out_flag), 32'd1);
    check("t3_ret_val", rd_val, 32'h55);
    check("t3_not_full", 32'(rob_full), 32'd0);
    check("t3_wrap_tag", 32'(alloc_tag), 32'd0);
    alloc(1'b1, 5'd20);
    check("t3_wrap_next", 32'(alloc_tag), 32'd1);
    check("t3_refull", 32'(rob_full), 32'd1);
    // full + retire in the same cycle: allocation still ignored
    cdb(4'd1, 32'h66, 1'b0, 32'h0);
    alloc(1'b1, 5'd21);
    check("t3_fr_flag", 32'(rd_out_flag), 32'd1);
    check("t3_fr_rd", 32'(rd_out), 32'd2);
    check("t3_fr_tag", 32'(alloc_tag), 32'd1);
    check("t3_fr_full", 32'(rob_full), 32'd0);

    // 4. Mispredicted branch flush
    do_reset();
    alloc(1'b1, 5'd7);
    alloc(1'b1, 5'd8);
    alloc(1'b1, 5'd9);
    cdb(4'd1, 32'h88, 1'b0, 32'h0);
    cdb(4'd0, 32'h44, 1'b1, 32'h100);
    check("t4_no_flush_yet", 32'(flush_out), 32'd0);
    tick();
    check("t4_flush", 32'(flush_out), 32'd1);
    check("t4_flush_pc", flush_pc, 32'h100);
    check("t4_br_flag", 32'(rd_out_flag), 32'd1);
    check("t4_br_rd", 32'(rd_out), 32'd7);
    check("t4_empty", 32'(rob_empty), 32'd1);
    check("t4_tag", 32'(alloc_tag), 32'd0);
    tick();
    check("t4_flush_pulse", 32'(flush_out), 32'd0);
    check("t4_no_retire1", 32'(rd_out_flag), 32'd0);
    tick();
    check("t4_no_retire2", 32'(rd_out_flag), 32'd0);

    // 5. Operand forwarding
    for (int i = 0; i < 5; i++) alloc(1'b1, 5'(10 + i));
    q1_tag = 4'd3; q2_tag = 4'd4;
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_val = 32'hDEAD;
    #1;
    check("t5_q1_bypass_rdy", 32'(q1_ready), 32'd1);
    check("t5_q1_bypass_val", q1_val, 32'hDEAD);
    check("t5_q2_not_rdy", 32'(q2_ready), 32'd0);
    tick();
    cdb_valid = 1'b0;
    #1;
    check("t5_q1_stored_rdy", 32'(q1_ready), 32'd1);
    check("t5_q1_stored_val", q1_val, 32'hDEAD);
    q1_tag = 4'd0;
    #1;
    check("t5_q1_busy_not_rdy", 32'(q1_ready), 32'd0);

    // 6. rdy hold, then mid-operation reset
    cdb(4'd0, 32'h77, 1'b0, 32'h0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_hold_flag", 32'(rd_out_flag), 32'd0);
    end
    check("t6_hold_tag", 32'(alloc_tag), 32'd5);
    check("t6_hold_q1", 32'(q1_ready), 32'd1);
    rdy = 1'b1;
    tick();
    check("t6_ret_flag", 32'(rd_out_flag), 32'd1);
    check("t6_ret_rd", 32'(rd_out), 32'd10);
    check("t6_ret_val", rd_val, 32'h77);
    cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_val = 32'h99;
    alloc(1'b1, 5'd15);
    cdb_valid = 1'b0;
    check("t6_pre_rst_tag", 32'(alloc_tag), 32'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_empty", 32'(rob_empty), 32'd1);
    check("t6_rst_flag", 32'(rd_out_flag), 32'd0);
    check("t6_rst_tag", 32'(alloc_tag), 32'd0);
    tick();
    check("t6_post_rst_flag", 32'(rd_out_flag), 32'd0);
    check("t6_post_rst_empty", 32'(rob_empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
